// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, control tokens and a ones-count helper.
package tmds_pkg;

  localparam int TMDS_SYM_W = 10;

  localparam logic [TMDS_SYM_W-1:0] TMDS_CTL0 = 10'b1101010100;
  localparam logic [TMDS_SYM_W-1:0] TMDS_CTL1 = 10'b0010101011;
  localparam logic [TMDS_SYM_W-1:0] TMDS_CTL2 = 10'b0101010100;
  localparam logic [TMDS_SYM_W-1:0] TMDS_CTL3 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// TMDS transition-minimisation ranks: input capture (S1) and q_m generation (S2).
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clkin,
  input  logic       rstin,
  input  logic [7:0] din,
  input  logic       de,
  input  logic       c0,
  input  logic       c1,
  output logic [8:0] q_m_p1,
  output logic [3:0] n1q_p1,
  output logic [3:0] n0q_p1,
  output logic       vld_p1,
  output logic [1:0] ctl_p1
);

  logic [7:0] din_p0;
  logic       vld_p0;
  logic [1:0] ctl_p0;
  logic [3:0] n1d_p0;
  logic [8:0] q_m;
  logic [3:0] n1q;

  // S1: capture the pixel slot together with its ones count
  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      din_p0 <= '0;
      vld_p0 <= 1'b0;
      ctl_p0 <= '0;
      n1d_p0 <= '0;
    end else begin
      din_p0 <= din;
      vld_p0 <= de;
      ctl_p0 <= {c1, c0};
      n1d_p0 <= popcount8(din);
    end
  end

  // Pick the XOR or XNOR chain (whichever gives fewer transitions) and build q_m
  always_comb begin
    logic       use_xnor;
    logic [8:0] qm_v;
    use_xnor = (n1d_p0 > 4'd4) || ((n1d_p0 == 4'd4) && !din_p0[0]);
    qm_v     = '0;
    qm_v[0]  = din_p0[0];
    for (int i = 1; i < 8; i++) begin
      qm_v[i] = use_xnor ? ~(qm_v[i-1] ^ din_p0[i]) : (qm_v[i-1] ^ din_p0[i]);
    end
    qm_v[8] = ~use_xnor;
    q_m     = qm_v;
    n1q     = popcount8(qm_v[7:0]);
  end

  // S2: register q_m and its ones/zeros counts for the balance stage
  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      q_m_p1 <= '0;
      n1q_p1 <= '0;
      n0q_p1 <= '0;
      vld_p1 <= 1'b0;
      ctl_p1 <= '0;
    end else begin
      q_m_p1 <= q_m;
      n1q_p1 <= n1q;
      n0q_p1 <= 4'd8 - n1q;
      vld_p1 <= vld_p0;
      ctl_p1 <= ctl_p0;
    end
  end

endmodule

// File: rtl/tmds_encoder_8b10b.sv
// Per-channel TMDS 8b/10b encoder: q_m stages plus DC-balance / control-token rank (S3).
module tmds_encoder_8b10b
  import tmds_pkg::*;
#(
  parameter int DISP_W = 5
)
(
  input  logic                  clkin,
  input  logic                  rstin,
  input  logic [7:0]            din,
  input  logic                  c0,
  input  logic                  c1,
  input  logic                  de,
  output logic [TMDS_SYM_W-1:0] dout
);

  logic [8:0] q_m_p1;
  logic [3:0] n1q_p1;
  logic [3:0] n0q_p1;
  logic       vld_p1;
  logic [1:0] ctl_p1;

  logic signed [DISP_W-1:0] cnt_p2;
  logic signed [DISP_W-1:0] cnt_nxt;
  logic signed [DISP_W-1:0] disp;
  logic signed [DISP_W-1:0] qm8_x2;
  logic signed [DISP_W-1:0] nqm8_x2;
  logic [TMDS_SYM_W-1:0]    sym_nxt;
  logic                     cnt_zero;
  logic                     disp_zero;
  logic                     same_sign;

  tmds_qm_stage u_qm (
    .clkin  (clkin),
    .rstin  (rstin),
    .din    (din),
    .de     (de),
    .c0     (c0),
    .c1     (c1),
    .q_m_p1 (q_m_p1),
    .n1q_p1 (n1q_p1),
    .n0q_p1 (n0q_p1),
    .vld_p1 (vld_p1),
    .ctl_p1 (ctl_p1)
  );

  // Choose the output symbol and the running-disparity update for this slot
  always_comb begin
    disp      = DISP_W'(n1q_p1) - DISP_W'(n0q_p1);
    qm8_x2    = DISP_W'({q_m_p1[8], 1'b0});
    nqm8_x2   = DISP_W'({~q_m_p1[8], 1'b0});
    cnt_zero  = (cnt_p2 == '0);
    disp_zero = (disp == '0);
    same_sign = !cnt_zero && !disp_zero && (cnt_p2[DISP_W-1] == disp[DISP_W-1]);
    sym_nxt   = TMDS_CTL0;
    cnt_nxt   = '0;
    if (!vld_p1) begin
      // Blanking resets the disparity so every active line starts balanced
      case (ctl_p1)
        2'b00:   sym_nxt = TMDS_CTL0;
        2'b01:   sym_nxt = TMDS_CTL1;
        2'b10:   sym_nxt = TMDS_CTL2;
        default: sym_nxt = TMDS_CTL3;
      endcase
    end else if (cnt_zero || disp_zero) begin
      sym_nxt = {~q_m_p1[8], q_m_p1[8], q_m_p1[8] ? q_m_p1[7:0] : ~q_m_p1[7:0]};
      cnt_nxt = q_m_p1[8] ? (cnt_p2 + disp) : (cnt_p2 - disp);
    end else if (same_sign) begin
      sym_nxt = {1'b1, q_m_p1[8], ~q_m_p1[7:0]};
      cnt_nxt = cnt_p2 + qm8_x2 - disp;
    end else begin
      sym_nxt = {1'b0, q_m_p1[8], q_m_p1[7:0]};
      cnt_nxt = cnt_p2 + disp - nqm8_x2;
    end
  end

  // S3: register the symbol and the running disparity
  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      dout   <= '0;
      cnt_p2 <= '0;
    end else begin
      dout   <= sym_nxt;
      cnt_p2 <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// Bench for tmds_encoder_8b10b: directed vector table, async reset sequences, random stream vs model.
module tb_tmds_encoder_8b10b;

  localparam int DISP_W = 5;

  logic       clkin = 1'b0;
  logic       rstin;
  logic [7:0] din;
  logic       c0;
  logic       c1;
  logic       de;
  logic [9:0] dout;

  tmds_encoder_8b10b #(.DISP_W(DISP_W)) dut (
    .clkin (clkin),
    .rstin (rstin),
    .din   (din),
    .c0    (c0),
    .c1    (c1),
    .de    (de),
    .dout  (dout)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [9:0] sym;
    int         cnt;
    logic       de;
    logic [7:0] din;
    bit         chk;
  } slot_t;

  typedef struct {
    logic [7:0] din;
    logic       de;
    logic [1:0] c;
    logic [9:0] exp;
    int         exp_cnt;
  } vec_t;

  slot_t hist [3];
  int    m_cnt;
  vec_t  tbl [16];

  task automatic check_sym(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dout=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] b;
    logic [7:0] d;
    b    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    end
    return d;
  endfunction

  // Behavioural encoder; updates m_cnt
  task automatic model_step(input logic [7:0] d, input logic e, input logic [1:0] c,
                            output logic [9:0] sym);
    int         ones;
    int         disp;
    logic       inv;
    logic [8:0] q;
    if (!e) begin
      case (c)
        2'b00:   sym = 10'h354;
        2'b01:   sym = 10'h0AB;
        2'b10:   sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
      m_cnt = 0;
      return;
    end
    ones = $countones(d);
    inv  = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = inv ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = !inv;
    disp = 2 * $countones(q[7:0]) - 8;
    if (m_cnt == 0 || disp == 0) begin
      sym   = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      m_cnt = q[8] ? (m_cnt + disp) : (m_cnt - disp);
    end else if ((m_cnt > 0 && disp > 0) || (m_cnt < 0 && disp < 0)) begin
      sym   = {1'b1, q[8], ~q[7:0]};
      m_cnt = m_cnt + 2 * int'(q[8]) - disp;
    end else begin
      sym   = {1'b0, q[8], q[7:0]};
      m_cnt = m_cnt + disp - 2 * int'(!q[8]);
    end
  endtask

  task automatic clear_model();
    m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      hist[i].chk = 1'b0;
    end
  endtask

  // One pixel slot: drive at negedge, clock it in, check the slot from two edges ago
  task automatic drive(input logic [7:0] d, input logic e, input logic [1:0] c);
    logic [9:0] sym;
    din = d;
    de  = e;
    c1  = c[1];
    c0  = c[0];
    model_step(d, e, c, sym);
    @(posedge clkin);
    hist[2]     = hist[1];
    hist[1]     = hist[0];
    hist[0].sym = sym;
    hist[0].cnt = m_cnt;
    hist[0].de  = e;
    hist[0].din = d;
    hist[0].chk = 1'b1;
    @(negedge clkin);
    if (hist[2].chk) begin
      check_sym("model_sym", dout, hist[2].sym);
      check_int("model_cnt", int'(dut.cnt_p2), hist[2].cnt);
      if (hist[2].cnt < -16 || hist[2].cnt > 15) begin
        check_int("cnt_range", hist[2].cnt, 0);
      end
      if (hist[2].de) begin
        check_sym("decode", {2'b00, decode(dout)}, {2'b00, hist[2].din});
      end
    end
  endtask

  // Assert reset between edges while data is flowing, then release at a negedge
  task automatic mid_reset();
    @(negedge clkin);
    #2 rstin = 1'b1;
    #1;
    check_sym("async_reset_dout", dout, 10'h000);
    check_int("async_reset_cnt", int'(dut.cnt_p2), 0);
    @(posedge clkin);
    @(negedge clkin);
    check_sym("reset_hold_dout", dout, 10'h000);
    rstin = 1'b0;
    clear_model();
  endtask

  task automatic random_run(input int cycles);
    int         run;
    logic       e;
    logic [1:0] c;
    run = 0;
    e   = 1'b0;
    c   = 2'b00;
    for (int i = 0; i < cycles; i++) begin
      if (run == 0) begin
        e   = ($urandom_range(0, 3) != 0);
        c   = 2'($urandom_range(0, 3));
        run = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 60);
      end
      run--;
      drive(8'($urandom_range(0, 255)), e, c);
    end
  endtask

  initial begin
    tbl[0]  = '{8'h00, 1'b0, 2'b00, 10'h354,  0};
    tbl[1]  = '{8'h00, 1'b0, 2'b01, 10'h0AB,  0};
    tbl[2]  = '{8'h00, 1'b0, 2'b10, 10'h154,  0};
    tbl[3]  = '{8'h00, 1'b0, 2'b11, 10'h2AB,  0};
    tbl[4]  = '{8'h00, 1'b1, 2'b00, 10'h100, -8};
    tbl[5]  = '{8'h00, 1'b1, 2'b00, 10'h3FF,  2};
    tbl[6]  = '{8'h00, 1'b0, 2'b00, 10'h354,  0};
    tbl[7]  = '{8'h00, 1'b1, 2'b00, 10'h100, -8};
    tbl[8]  = '{8'h00, 1'b0, 2'b00, 10'h354,  0};
    tbl[9]  = '{8'hFF, 1'b1, 2'b00, 10'h200, -8};
    tbl[10] = '{8'hFF, 1'b1, 2'b00, 10'h0FF, -2};
    tbl[11] = '{8'h00, 1'b1, 2'b00, 10'h3FF,  8};
    tbl[12] = '{8'hF0, 1'b1, 2'b00, 10'h205,  4};
    tbl[13] = '{8'h0F, 1'b1, 2'b00, 10'h105,  0};
    tbl[14] = '{8'h0F, 1'b1, 2'b00, 10'h105, -4};
    tbl[15] = '{8'h00, 1'b0, 2'b11, 10'h2AB,  0};

    rstin = 1'b1;
    din   = 8'h00;
    de    = 1'b0;
    c0    = 1'b0;
    c1    = 1'b0;
    clear_model();

    // Held reset
    repeat (3) @(posedge clkin);
    @(negedge clkin);
    check_sym("reset_dout", dout, 10'h000);
    check_int("reset_cnt", int'(dut.cnt_p2), 0);
    #2 rstin = 1'b0;

    // Blanking after release: token 00 by the third edge
    drive(8'h00, 1'b0, 2'b00);
    drive(8'h00, 1'b0, 2'b00);
    drive(8'h00, 1'b0, 2'b00);
    check_sym("release_3rd_edge", dout, 10'h354);

    // Directed vector table, each symbol checked two clocks after it is driven
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive(tbl[i].din, tbl[i].de, tbl[i].c);
      else        drive(8'h00, 1'b0, 2'b00);
      if (i >= 2) begin
        check_sym($sformatf("vec%0d_sym", i - 2), dout, tbl[i-2].exp);
        check_int($sformatf("vec%0d_cnt", i - 2), int'(dut.cnt_p2), tbl[i-2].exp_cnt);
      end
    end

    // Mid-stream reset while tokens are on the output
    mid_reset();

    // Build nonzero disparity, then reset mid-frame and confirm restart from cnt=0
    drive(8'h00, 1'b1, 2'b00);
    drive(8'h00, 1'b1, 2'b00);
    drive(8'h00, 1'b1, 2'b00);
    drive(8'h00, 1'b1, 2'b00);
    mid_reset();
    drive(8'h00, 1'b1, 2'b00);
    drive(8'h00, 1'b0, 2'b00);
    drive(8'h00, 1'b0, 2'b00);
    check_sym("restart_first_word", dout, 10'h100);
    check_int("restart_cnt", int'(dut.cnt_p2), -8);

    // Alternating de every cycle
    for (int i = 0; i < 40; i++) begin
      drive(8'($urandom_range(0, 255)), 1'(i % 2), 2'($urandom_range(0, 3)));
    end

    random_run(10000);
    mid_reset();
    random_run(10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
